// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: op encodings (common with the
// external ALU), FSM state encoding and an arithmetic-op classifier.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_INC   = 3'd2;
    localparam logic [2:0] OP_DEC   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_XOR   = 3'd6;
    localparam logic [2:0] OP_COMPL = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } seq_state_e;

    // Arithmetic ops are the only ones whose alu_out MSB is a real carry/borrow.
    function automatic logic is_arith(input logic [2:0] op);
        return (op <= OP_DEC);
    endfunction

    // Ops whose MSB means carry-out (as opposed to borrow).
    function automatic logic is_incr(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_INC);
    endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// Result shaping for the sequencer: turns the raw (N+1)-bit ALU result into the
// next accumulator value and carry flag. Logic ops have their MSB masked because
// the complement op drives it high. Saturate clamps on carry/borrow instead of
// wrapping; the reported carry is always the raw one.
module alu_seq_flags
    import alu_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter bit          Saturate = 1'b0
) (
    input  logic [N:0]   alu_out,
    input  logic [2:0]   alu_sel,
    output logic [N-1:0] acc_next,
    output logic         carry_next
);

    logic arith;
    logic raw_carry;

    assign arith     = is_arith(alu_sel);
    assign raw_carry = alu_out[N];

    // Select the accumulator update and masked carry for the executed op.
    always_comb begin
        acc_next   = alu_out[N-1:0];
        carry_next = arith & raw_carry;
        if (Saturate && arith && raw_carry) begin
            acc_next = is_incr(alu_sel) ? {N{1'b1}} : {N{1'b0}};
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven accumulator sequencer wrapped around an external combinational
// ALU. Registers ALU operands/select, captures the ALU result into the
// accumulator and returns it with carry/zero flags over a valid/ready channel.
// Build option: define ALU_SEQ_SATURATE_EN to saturate add/inc and sub/dec
// instead of wrapping modulo 2^N.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_load,
    input  logic [N-1:0] cmd_data,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [N:0]   alu_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_carry,
    output logic         res_zero
);

`ifdef ALU_SEQ_SATURATE_EN
    localparam bit Saturate = 1'b1;
`else
    localparam bit Saturate = 1'b0;
`endif

    seq_state_e   state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic [2:0]   alu_sel_q, alu_sel_d;
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;

    logic [N-1:0] flags_acc;
    logic         flags_carry;

    alu_seq_flags #(
        .N        (N),
        .Saturate (Saturate)
    ) u_flags (
        .alu_out    (alu_out),
        .alu_sel    (alu_sel_q),
        .acc_next   (flags_acc),
        .carry_next (flags_carry)
    );

    // Next-state and datapath updates for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_d   = cmd_data;
                        carry_d = 1'b0;
                        zero_d  = (cmd_data == '0);
                        state_d = StResp;
                    end else begin
                        alu_a_d   = acc_q;
                        alu_b_d   = cmd_data;
                        alu_sel_d = cmd_op;
                        state_d   = StExec;
                    end
                end
            end
            StExec: begin
                acc_d   = flags_acc;
                carry_d = flags_carry;
                zero_d  = (flags_acc == '0);
                state_d = StResp;
            end
            StResp: begin
                // Return to IDLE only; a new command waits for the following cycle.
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
        end
    end

    // Reset gating keeps cmd_ready low while rst_n is asserted.
    assign cmd_ready = (state_q == StIdle) && rst_n;
    assign res_valid = (state_q == StResp);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_data  = acc_q;
    assign res_carry = carry_q;
    assign res_zero  = zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer. Supplies a reference
// combinational ALU and checks results, flags, handshake timing, stalls and reset
// abort. Expected values follow ALU_SEQ_SATURATE_EN when it is defined.
module tb_alu_op_sequencer;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic         cmd_load;
    logic [N-1:0] cmd_data;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_sel;
    logic [N:0]   alu_out;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_carry;
    logic         res_zero;

    int checks;
    int passes;

`ifdef ALU_SEQ_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    alu_op_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_load  (cmd_load),
        .cmd_data  (cmd_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: MSB is carry for add/inc, borrow for sub/dec, 1 for complement.
    always_comb begin
        case (alu_sel)
            3'd0:    alu_out = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    alu_out = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2:    alu_out = {1'b0, alu_a} + 5'd1;
            3'd3:    alu_out = {1'b0, alu_a} - 5'd1;
            3'd4:    alu_out = {1'b0, alu_a & alu_b};
            3'd5:    alu_out = {1'b0, alu_a | alu_b};
            3'd6:    alu_out = {1'b0, alu_a ^ alu_b};
            default: alu_out = {1'b1, ~alu_a};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [3:0] d, input logic c,
                             input logic z);
        chk({tag, " res_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, " res_data"}, {28'd0, res_data}, {28'd0, d});
        chk({tag, " res_carry"}, {31'd0, res_carry}, {31'd0, c});
        chk({tag, " res_zero"}, {31'd0, res_zero}, {31'd0, z});
    endtask

    task automatic finish_res(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, " idle res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, " idle cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic do_load(input string tag, input logic [3:0] d);
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_op    = 3'd6;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        check_res(tag, d, 1'b0, d == 4'd0);
        finish_res(tag);
    endtask

    // Accept edge puts the sequencer in EXEC; result is visible after the next edge.
    task automatic do_alu(input string tag, input logic [2:0] op, input logic [3:0] b,
                          input logic [3:0] a, input logic [3:0] d, input logic c,
                          input logic z);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = op;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
        chk({tag, " exec res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, " exec cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        chk({tag, " alu_a"}, {28'd0, alu_a}, {28'd0, a});
        chk({tag, " alu_b"}, {28'd0, alu_b}, {28'd0, b});
        chk({tag, " alu_sel"}, {29'd0, alu_sel}, {29'd0, op});
        tick();
        check_res(tag, d, c, z);
        finish_res(tag);
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'd0;
        res_ready = 1'b0;
        #3;
        chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst res_data", {28'd0, res_data}, 32'd0);
        chk("rst res_carry", {31'd0, res_carry}, 32'd0);
        chk("rst res_zero", {31'd0, res_zero}, 32'd0);
        chk("rst alu_a", {28'd0, alu_a}, 32'd0);
        chk("rst alu_b", {28'd0, alu_b}, 32'd0);
        chk("rst alu_sel", {29'd0, alu_sel}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post-rst cmd_ready", {31'd0, cmd_ready}, 32'd1);

        do_load("load9", 4'h9);
        if (Sat) do_alu("add9", 3'd0, 4'h9, 4'h9, 4'hF, 1'b1, 1'b0);
        else     do_alu("add9", 3'd0, 4'h9, 4'h9, 4'h2, 1'b1, 1'b0);

        do_load("load2", 4'h2);
        if (Sat) begin
            do_alu("sub3", 3'd1, 4'h3, 4'h2, 4'h0, 1'b1, 1'b1);
            do_alu("compl", 3'd7, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
        end else begin
            do_alu("sub3", 3'd1, 4'h3, 4'h2, 4'hF, 1'b1, 1'b0);
            do_alu("compl", 3'd7, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1);
        end

        do_load("loadC", 4'hC);
        do_alu("andA", 3'd4, 4'hA, 4'hC, 4'h8, 1'b0, 1'b0);
        do_alu("xor3", 3'd6, 4'h3, 4'h8, 4'hB, 1'b0, 1'b0);

        // Stall in RESP with a competing load offered; it must not be taken.
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_data  = 4'h5;
        tick();
        cmd_data  = 4'hA;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_res("stall", 4'h5, 1'b0, 1'b0);
            chk("stall cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        finish_res("stall");
        do_alu("or0", 3'd5, 4'h0, 4'h5, 4'h5, 1'b0, 1'b0);

        // Reset during EXEC of an ADD aborts it.
        do_load("load3", 4'h3);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_data  = 4'h4;
        tick();
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("abort res_valid", {31'd0, res_valid}, 32'd0);
        chk("abort cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("abort alu_a", {28'd0, alu_a}, 32'd0);
        chk("abort alu_b", {28'd0, alu_b}, 32'd0);
        chk("abort res_data", {28'd0, res_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort no res_valid", {31'd0, res_valid}, 32'd0);
        end
        do_alu("or0 after abort", 3'd5, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

        if (Sat) do_alu("dec0", 3'd3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        else     do_alu("dec0", 3'd3, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
        do_load("loadF", 4'hF);
        if (Sat) do_alu("incF", 3'd2, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0);
        else     do_alu("incF", 3'd2, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
